db_reg_reader: RTL and testbench
================================

DB_REG_READER -- requirements
Module: db_reg_reader

Interface
REQ-001 SHALL have parameter: NUM_REGS, 32, number of registers dumped (addresses 0..NUM_REGS-1); legal range 1..32.
REQ-002 SHALL have port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  in  1  dump request, sampled only in IDLE.
REQ-005 SHALL have port: DB_Stall  out  1  pipeline freeze, drives decode stage stall input.
REQ-006 SHALL have port: DB_Lector  out  1  debug-read select; forces register-file read port A to DB_DirReg and blocks register writes.
REQ-007 SHALL have port: DB_DirReg  out  5  register address presented to read port A.
REQ-008 SHALL have port: DB_RegisterA  in  32  read-port-A data from decode stage; updated on the falling edge after DB_DirReg changes.
REQ-009 SHALL have port: tx_data  out  8  byte to serial transmitter.
REQ-010 SHALL have port: tx_valid  out  1  tx_data valid.
REQ-011 SHALL have port: tx_ready  in  1  transmitter accepts byte.
REQ-012 SHALL have port: busy  out  1  high from the start-accept edge until the done edge.
REQ-013 SHALL have port: done  out  1  one-cycle pulse at dump completion.

Function
REQ-014 SHALL implement states IDLE, CAPTURE, SEND, DONE; all outputs registered.
REQ-015 IDLE with start=1 at edge S: SHALL set DB_Stall=1, DB_Lector=1, busy=1, DB_DirReg=0, go to CAPTURE.
REQ-016 CAPTURE (one cycle): SHALL load DB_RegisterA into a 32-bit shift register, set tx_valid=1 and tx_data=bits[31:24], go to SEND.
REQ-017 Capture SHALL occur exactly one rising edge after DB_DirReg update (the intervening falling edge refreshes DB_RegisterA).
REQ-018 SEND: a byte transfers on each rising edge with tx_valid=1 and tx_ready=1; bytes go MSB first (31:24, 23:16, 15:8, 7:0).
REQ-019 tx_data SHALL hold stable while tx_valid=1 and tx_ready=0; tx_valid never drops before the transfer.
REQ-020 On 4th-byte transfer with DB_DirReg<NUM_REGS-1: SHALL drop tx_valid, increment DB_DirReg, go to CAPTURE.
REQ-021 On 4th-byte transfer with DB_DirReg=NUM_REGS-1: SHALL drop tx_valid, DB_Stall, DB_Lector and busy, set done=1, go to DONE.
REQ-022 DONE: SHALL clear done and return to IDLE after one cycle; start is ignored in DONE.
REQ-023 start SHALL be ignored whenever busy=1; no queuing of requests.
REQ-024 Byte count SHALL wrap 3->0 per register; DB_DirReg SHALL never exceed NUM_REGS-1.
REQ-025 With tx_ready held 1: 5 cycles per register; done asserted at edge S+5*NUM_REGS (S+160 for 32).
REQ-026 DB_DirReg SHALL stay stable from its update through the capture edge.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE and DB_Stall=0, DB_Lector=0, DB_DirReg=0, tx_data=0, tx_valid=0, busy=0, done=0, shift register and byte count =0.
REQ-028 Reset mid-dump SHALL abort without completing the current byte; after release, state is IDLE and a new start begins at address 0.

Verification
REQ-029 Full dump, tx_ready=1, reg2=0x00000002, others 0: start at S -> 128 bytes, bytes 8..11 = 00 00 00 02, rest 00, done at S+160, DB_Stall high S..S+160.
REQ-030 Backpressure: tx_ready=0 for 7 cycles during byte 1 of register 5=0xA1B2C3D4 -> tx_data=0xB2 held stable, sequence A1 B2 C3 D4 intact, done delayed by 7 cycles.
REQ-031 start pulsed at S+20 during dump -> ignored; exactly 128 bytes, single done pulse.
REQ-032 rst_n low at S+50 for 2 cycles -> all outputs 0 asynchronously; new start yields a complete 128-byte dump from address 0.
REQ-033 NUM_REGS=1, tx_ready=1, reg0=0x12345678 -> bytes 12 34 56 78, done at S+5, DB_Lector high S..S+5 only.
REQ-034 Decode-stage write attempted during dump (write-enable high, reg 2 <- 0xFFFFFFFF) -> dumped reg2 = 0x00000002, register file unchanged.

Source files
------------

// File: rtl/db_reg_reader_if.sv
// Byte stream from the register dumper to the serial transmitter.
//   tx_data  : byte being offered (master -> slave)
//   tx_valid : tx_data is valid (master -> slave)
//   tx_ready : transmitter accepts the byte this edge (slave -> master)
interface db_reg_reader_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface : db_reg_reader_if

// File: rtl/db_reg_reader.sv
// Debug register dumper: freezes the pipeline, walks register-file read
// port A over addresses 0..NUM_REGS-1 and streams each 32-bit value to the
// serial transmitter MSB byte first.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : dump request, sampled only in IDLE
//   DB_Stall     : decode-stage stall while dumping
//   DB_Lector    : debug-read select (steers read port A, blocks writes)
//   DB_DirReg    : address presented to read port A
//   DB_RegisterA : read port A data, refreshed on the falling edge
//   busy, done   : dump in progress / one-cycle completion pulse
//   tx           : byte stream to the transmitter (valid/ready)
module db_reg_reader #(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  DB_Stall,
    output logic                  DB_Lector,
    output logic [4:0]            DB_DirReg,
    input  logic [31:0]           DB_RegisterA,
    output logic                  busy,
    output logic                  done,
    db_reg_reader_if.master       tx
);

    localparam logic [4:0] LAST_ADDR = 5'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SEND    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] shift_q;
    logic [1:0]  byte_cnt;
    logic        tx_valid_q;

    // The top byte of the shift register is the byte on offer, so tx_data
    // comes straight from a flop and cannot change while a byte is pending.
    assign tx.tx_data  = shift_q[31:24];
    assign tx.tx_valid = tx_valid_q;

    // Dump sequencer: one capture cycle plus four byte transfers per register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            DB_Stall   <= 1'b0;
            DB_Lector  <= 1'b0;
            DB_DirReg  <= 5'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            shift_q    <= 32'd0;
            byte_cnt   <= 2'd0;
            tx_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        DB_Stall  <= 1'b1;
                        DB_Lector <= 1'b1;
                        busy      <= 1'b1;
                        DB_DirReg <= 5'd0;
                        state     <= CAPTURE;
                    end
                end

                // DB_DirReg changed on the previous edge; the falling edge in
                // between has refreshed DB_RegisterA, so it is safe to load.
                CAPTURE: begin
                    shift_q    <= DB_RegisterA;
                    byte_cnt   <= 2'd0;
                    tx_valid_q <= 1'b1;
                    state      <= SEND;
                end

                SEND: begin
                    if (tx_valid_q && tx.tx_ready) begin
                        shift_q  <= {shift_q[23:0], 8'h00};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            tx_valid_q <= 1'b0;
                            if (DB_DirReg == LAST_ADDR) begin
                                DB_Stall  <= 1'b0;
                                DB_Lector <= 1'b0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                state     <= DONE;
                            end else begin
                                DB_DirReg <= DB_DirReg + 5'd1;
                                state     <= CAPTURE;
                            end
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule : db_reg_reader

// File: tb/tb_db_reg_reader.sv
// Scoreboard bench for db_reg_reader: a 32-register instance with a small
// register-file model, plus a single-register instance.
module tb_db_reg_reader;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- 32-register instance ----------------
    logic        start0;
    logic        stall0, lector0, busy0, done0;
    logic [4:0]  dir0;
    logic [31:0] rega0;
    db_reg_reader_if tx0 ();

    db_reg_reader #(.NUM_REGS(32)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .DB_Stall(stall0), .DB_Lector(lector0), .DB_DirReg(dir0),
        .DB_RegisterA(rega0), .busy(busy0), .done(done0), .tx(tx0.master)
    );

    // Register file read port A, refreshed on the falling edge.
    logic [31:0] rf     [32];
    logic [31:0] exp_rf [32];
    always @(negedge clk) rega0 <= rf[lector0 ? dir0 : 5'd0];

    logic [7:0] sb0 [$];
    int         n_bytes0;

    // Byte monitor: pop and compare on every accepted byte; a byte on offer
    // but not accepted must still be there, unchanged, on the next cycle.
    bit         hold0 = 1'b0;
    logic [7:0] held0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold0 = 1'b0;
        end else if (tx0.tx_valid) begin
            if (hold0) chk("hold_stable", 32'(tx0.tx_data), 32'(held0));
            if (tx0.tx_ready) begin
                n_bytes0++;
                hold0 = 1'b0;
                if (sb0.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL extra_byte: got %h expected none at %0t", tx0.tx_data, $time);
                end else begin
                    chk("byte", 32'(tx0.tx_data), 32'(sb0.pop_front()));
                end
            end else begin
                hold0 = 1'b1;
                held0 = tx0.tx_data;
            end
        end else begin
            hold0 = 1'b0;
        end
    end

    // ---------------- single-register instance ----------------
    logic        start1;
    logic        stall1, lector1, busy1, done1;
    logic [4:0]  dir1;
    logic [31:0] rega1;
    db_reg_reader_if tx1 ();
    assign tx1.tx_ready = 1'b1;

    db_reg_reader #(.NUM_REGS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .DB_Stall(stall1), .DB_Lector(lector1), .DB_DirReg(dir1),
        .DB_RegisterA(rega1), .busy(busy1), .done(done1), .tx(tx1.master)
    );

    always @(negedge clk) rega1 <= (lector1 && dir1 == 5'd0) ? 32'h1234_5678 : 32'h0;

    logic [7:0] sb1 [$];
    int         n_bytes1;
    always @(negedge clk) begin
        if (rst_n && tx1.tx_valid && tx1.tx_ready) begin
            n_bytes1++;
            if (sb1.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL extra_byte1: got %h expected none at %0t", tx1.tx_data, $time);
            end else begin
                chk("byte1", 32'(tx1.tx_data), 32'(sb1.pop_front()));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_dump();
        for (int r = 0; r < 32; r++)
            for (int b = 0; b < 4; b++)
                sb0.push_back(8'(exp_rf[r] >> (24 - 8 * b)));
    endtask

    task automatic chk_all_zero0(input string name);
        chk(name, 32'({stall0, lector0, dir0, tx0.tx_data, tx0.tx_valid, busy0, done0}), 32'd0);
    endtask

    // One dump on u0; k counts rising edges after the start-accept edge S,
    // checks are taken on the falling edge after edge S+k.
    task automatic run_dump(input int exp_done, input bit bp, input bit mid,
                            input bit do_rst, input bit wr);
        int done_k   = -1;
        int done_cnt = 0;
        bit ctl_ok   = 1'b1;
        n_bytes0 = 0;
        push_dump();
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        for (int k = 0; k <= exp_done + 3; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            tx0.tx_ready = !(bp && k >= 27 && k <= 33);
            start0 = mid && (k == 20);
            // Decode-stage write to reg 2; the register file ignores it while
            // the debug read select is active.
            if (wr && k == 3 && !lector0) rf[2] = 32'hFFFF_FFFF;
            if (do_rst && k == 50) begin
                rst_n = 1'b0;
                #1 chk_all_zero0("async_reset");
                sb0.delete();
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                tx0.tx_ready = 1'b1;
                return;
            end
            @(negedge clk);
            if (done0) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (k == 12) chk("dir_reg2", 32'(dir0), 32'd2);
            if (bp && k == 30) chk("bp_data", 32'({tx0.tx_valid, tx0.tx_data}), 32'h1B2);
            if (k < exp_done)
                ctl_ok &= (stall0 && lector0 && busy0 && !done0);
            else if (k == exp_done)
                ctl_ok &= (!stall0 && !lector0 && !busy0 && done0);
            else
                ctl_ok &= (!stall0 && !lector0 && !busy0 && !done0);
        end
        chk("done_edge", 32'(done_k), 32'(exp_done));
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("ctl_window", 32'(ctl_ok), 32'd1);
        chk("byte_count", 32'(n_bytes0), 32'd128);
        chk("sb_empty", 32'(sb0.size()), 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        start0       = 1'b0;
        start1       = 1'b0;
        tx0.tx_ready = 1'b1;
        n_bytes0     = 0;
        n_bytes1     = 0;
        for (int r = 0; r < 32; r++) begin
            rf[r]     = 32'd0;
            exp_rf[r] = 32'd0;
        end
        rf[2]     = 32'h0000_0002;
        exp_rf[2] = 32'h0000_0002;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero0("reset_state0");
        chk("reset_state1", 32'({stall1, lector1, dir1, tx1.tx_data, tx1.tx_valid, busy1, done1}), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Full dump with a blocked write attempt to reg 2.
        run_dump(160, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);

        // Backpressure on byte 1 of reg 5.
        rf[5]     = 32'hA1B2_C3D4;
        exp_rf[5] = 32'hA1B2_C3D4;
        run_dump(167, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);

        // start pulse during the dump is ignored.
        run_dump(160, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);

        // Reset mid-dump, then a complete fresh dump from address 0.
        run_dump(160, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk_all_zero0("post_reset_idle");
        run_dump(160, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);

        // Single-register instance.
        begin
            int done_k = -1;
            bit ctl_ok = 1'b1;
            sb1.push_back(8'h12);
            sb1.push_back(8'h34);
            sb1.push_back(8'h56);
            sb1.push_back(8'h78);
            n_bytes1 = 0;
            @(posedge clk); #1 start1 = 1'b1;
            @(posedge clk); #1 start1 = 1'b0;
            for (int k = 0; k <= 8; k++) begin
                if (k > 0) begin
                    @(posedge clk); #1;
                end
                @(negedge clk);
                if (done1 && done_k < 0) done_k = k;
                ctl_ok &= (lector1 == (k < 5)) && (dir1 == 5'd0);
            end
            chk("done_edge1", 32'(done_k), 32'd5);
            chk("lector_window1", 32'(ctl_ok), 32'd1);
            chk("byte_count1", 32'(n_bytes1), 32'd4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_db_reg_reader
